// File: rtl/sr_trace_monitor.sv
// sr_trace_monitor: watches the sr_cpu fetch stream (pc, instr), turns each
// run of consecutive identical pc values into one retirement record
// {pc, instr, cycles}, counts EBREAK entries, halts on WFI and queues the
// records in a small FIFO so a slow reader (UART, debug port) can drain them.
module sr_trace_monitor #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pc,
  input  logic [31:0]      instr,
  input  logic             trace_ready,
  output logic             trace_valid,
  output logic [31:0]      trace_pc,
  output logic [31:0]      trace_instr,
  output logic [CNT_W-1:0] trace_cycles,
  output logic [CNT_W-1:0] error_count,
  output logic             halted,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSTR_WFI    = 32'h1050_0073;

  // Monitor mode: waiting for the first fetch, tracking instructions,
  // one extra edge to emit the WFI record, then frozen until reset.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WPEND = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Saturating increment shared by the cycle and error counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [31:0]      prev_pc_q, prev_pc_d;
  logic [31:0]      prev_instr_q, prev_instr_d;
  logic [CNT_W-1:0] cur_cnt_q, cur_cnt_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             ovf_q, ovf_d;

  logic             capture;     // load prev_* from the current fetch
  logic             hold;        // same instruction still at pc
  logic             rec_push;    // a record is offered to the FIFO
  logic             rec_wfi;     // the offered record is the WFI record

  logic [31:0]      rec_pc;
  logic [31:0]      rec_instr;
  logic [CNT_W-1:0] rec_cnt;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop;
  logic             push_ok;
  logic             push_drop;

  logic [31:0]      mem_pc_q    [DEPTH];
  logic [31:0]      mem_instr_q [DEPTH];
  logic [CNT_W-1:0] mem_cnt_q   [DEPTH];

  // Mode register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next mode and per-edge actions (capture, count, push).
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    hold     = 1'b0;
    rec_push = 1'b0;
    rec_wfi  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // First edge after reset only seeds the tracker; nothing to emit yet.
        capture = 1'b1;
        state_d = (instr == INSTR_WFI) ? ST_WPEND : ST_RUN;
      end
      ST_RUN: begin
        if (pc != prev_pc_q) begin
          rec_push = 1'b1;
          capture  = 1'b1;
          if (instr == INSTR_WFI) state_d = ST_WPEND;
        end else begin
          hold = 1'b1;
        end
      end
      ST_WPEND: begin
        // WFI is emitted with a fixed one-cycle occupancy, then we freeze.
        rec_push = 1'b1;
        rec_wfi  = 1'b1;
        state_d  = ST_HALT;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  // Record offered to the FIFO is always the instruction being left.
  always_comb begin
    rec_pc    = prev_pc_q;
    rec_instr = prev_instr_q;
    rec_cnt   = rec_wfi ? CNT_W'(1) : cur_cnt_q;
  end

  // Tracker and error counter next-state.
  always_comb begin
    prev_pc_d    = prev_pc_q;
    prev_instr_d = prev_instr_q;
    cur_cnt_d    = cur_cnt_q;
    err_d        = err_q;
    if (capture) begin
      prev_pc_d    = pc;
      prev_instr_d = instr;
      cur_cnt_d    = CNT_W'(1);
      if (instr == INSTR_EBREAK) err_d = sat_inc(err_q);
    end else if (hold) begin
      cur_cnt_d = sat_inc(cur_cnt_q);
    end
  end

  // Tracker and error counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_pc_q    <= '0;
      prev_instr_q <= '0;
      cur_cnt_q    <= '0;
      err_q        <= '0;
    end else begin
      prev_pc_q    <= prev_pc_d;
      prev_instr_q <= prev_instr_d;
      cur_cnt_q    <= cur_cnt_d;
      err_q        <= err_d;
    end
  end

  // FIFO status: pointers carry one extra wrap bit so full/empty differ
  // only in the MSB.
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop        = !fifo_empty && trace_ready;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    push_ok    = rec_push && (!fifo_full || pop);
    push_drop  = rec_push && fifo_full && !pop;
    wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop     ? rd_ptr_q + 1'b1 : rd_ptr_q;
    ovf_d      = ovf_q | push_drop;
  end

  // FIFO pointers and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_pc_q[wr_ptr_q[AW-1:0]]    <= rec_pc;
      mem_instr_q[wr_ptr_q[AW-1:0]] <= rec_instr;
      mem_cnt_q[wr_ptr_q[AW-1:0]]   <= rec_cnt;
    end
  end

  // Head record straight from storage, forced to zero while empty so the
  // outputs read 0 after reset.
  always_comb begin
    trace_valid  = !fifo_empty;
    trace_pc     = fifo_empty ? '0 : mem_pc_q[rd_ptr_q[AW-1:0]];
    trace_instr  = fifo_empty ? '0 : mem_instr_q[rd_ptr_q[AW-1:0]];
    trace_cycles = fifo_empty ? '0 : mem_cnt_q[rd_ptr_q[AW-1:0]];
    error_count  = err_q;
    halted       = (state_q == ST_HALT);
    overflow     = ovf_q;
  end

endmodule

// File: tb/tb_sr_trace_monitor.sv
// Directed bench for sr_trace_monitor with a 4-deep FIFO and 4-bit counters.
module tb_sr_trace_monitor;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  localparam logic [31:0] EBRK = 32'h0010_0073;
  localparam logic [31:0] WFI  = 32'h1050_0073;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      pc = 32'h0;
  logic [31:0]      instr = 32'h0;
  logic             trace_ready = 1'b0;
  logic             trace_valid;
  logic [31:0]      trace_pc;
  logic [31:0]      trace_instr;
  logic [CNT_W-1:0] trace_cycles;
  logic [CNT_W-1:0] error_count;
  logic             halted;
  logic             overflow;

  int n_assert = 0;
  int n_fail   = 0;

  sr_trace_monitor #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc           (pc),
    .instr        (instr),
    .trace_ready  (trace_ready),
    .trace_valid  (trace_valid),
    .trace_pc     (trace_pc),
    .trace_instr  (trace_instr),
    .trace_cycles (trace_cycles),
    .error_count  (error_count),
    .halted       (halted),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] nopi(input logic [31:0] p);
    return {p[11:0], 20'h00013};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input logic [31:0] p);
    pc    = p;
    instr = nopi(p);
  endtask

  // Reset pulse placed between edges; the next edge is the capture edge.
  task automatic do_reset(input logic [31:0] p, input logic [31:0] i);
    step();
    rst_n       = 1'b0;
    trace_ready = 1'b0;
    pc          = p;
    instr       = i;
    #2;
    rst_n       = 1'b1;
  endtask

  // Check the head record, then pop it with a one-cycle ready pulse.
  task automatic expect_rec(input string tag, input logic [31:0] p,
                            input logic [31:0] i, input logic [31:0] c);
    chk({tag, ".valid"}, 32'(trace_valid), 32'd1);
    chk({tag, ".pc"}, trace_pc, p);
    chk({tag, ".instr"}, trace_instr, i);
    chk({tag, ".cycles"}, 32'(trace_cycles), c);
    trace_ready = 1'b1;
    step();
    trace_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst.valid", 32'(trace_valid), 32'd0);
    chk("rst.pc", trace_pc, 32'd0);
    chk("rst.err", 32'(error_count), 32'd0);
    chk("rst.halted", 32'(halted), 32'd0);
    chk("rst.ovf", 32'(overflow), 32'd0);

    // Sequential fetch
    do_reset(32'h0, nopi(32'h0));
    step();
    chk("seq.first_edge_no_push", 32'(trace_valid), 32'd0);
    set_pc(32'h4); step();
    set_pc(32'h8); step();
    expect_rec("seq0", 32'h0, nopi(32'h0), 32'd1);
    expect_rec("seq1", 32'h4, nopi(32'h4), 32'd1);
    chk("seq.empty", 32'(trace_valid), 32'd0);
    chk("seq.err", 32'(error_count), 32'd0);
    chk("seq.halted", 32'(halted), 32'd0);

    // Stall of 5 cycles
    do_reset(32'h10, nopi(32'h10));
    repeat (5) step();
    set_pc(32'h14); step();
    expect_rec("stall", 32'h10, nopi(32'h10), 32'd5);

    // Cycle counter saturation at 15
    do_reset(32'h40, nopi(32'h40));
    repeat (20) step();
    set_pc(32'h44); step();
    expect_rec("sat", 32'h40, nopi(32'h40), 32'd15);

    // EBREAK entered twice, held once
    do_reset(32'h1C, nopi(32'h1C));
    step();
    pc = 32'h20; instr = EBRK; step();
    chk("ebrk.first", 32'(error_count), 32'd1);
    repeat (2) step();
    chk("ebrk.held", 32'(error_count), 32'd1);
    set_pc(32'h24); step();
    pc = 32'h20; instr = EBRK; step();
    chk("ebrk.second", 32'(error_count), 32'd2);
    chk("ebrk.ovf", 32'(overflow), 32'd0);
    expect_rec("ebrk0", 32'h1C, nopi(32'h1C), 32'd1);
    expect_rec("ebrk1", 32'h20, EBRK, 32'd3);
    expect_rec("ebrk2", 32'h24, nopi(32'h24), 32'd1);
    chk("ebrk.after_pops", 32'(error_count), 32'd2);

    // WFI halt
    do_reset(32'h30, 32'h0000_0513);
    step();
    step();
    pc = 32'h34; instr = WFI; step();
    chk("wfi.not_yet", 32'(halted), 32'd0);
    set_pc(32'h38); step();
    chk("wfi.halted", 32'(halted), 32'd1);
    set_pc(32'h3C); step();
    set_pc(32'h40); step();
    expect_rec("wfi0", 32'h30, 32'h0000_0513, 32'd2);
    expect_rec("wfi1", 32'h34, WFI, 32'd1);
    chk("wfi.no_more", 32'(trace_valid), 32'd0);
    chk("wfi.sticky", 32'(halted), 32'd1);

    // Backpressure with overflow, then drain (first pop overlaps a push)
    do_reset(32'h100, nopi(32'h100));
    step();
    for (int k = 1; k <= 4; k++) begin
      set_pc(32'h100 + 32'(4 * k)); step();
    end
    chk("bp.no_ovf_yet", 32'(overflow), 32'd0);
    for (int k = 5; k <= 6; k++) begin
      set_pc(32'h100 + 32'(4 * k)); step();
    end
    chk("bp.ovf", 32'(overflow), 32'd1);
    chk("bp.head_pc", trace_pc, 32'h100);
    chk("bp.head_cyc", 32'(trace_cycles), 32'd1);
    trace_ready = 1'b1;
    set_pc(32'h11C);
    step();
    trace_ready = 1'b0;
    expect_rec("bp1", 32'h104, nopi(32'h104), 32'd1);
    expect_rec("bp2", 32'h108, nopi(32'h108), 32'd1);
    expect_rec("bp3", 32'h10C, nopi(32'h10C), 32'd1);
    expect_rec("bp4", 32'h118, nopi(32'h118), 32'd1);
    chk("bp.empty", 32'(trace_valid), 32'd0);

    // Asynchronous reset in the middle of a run
    do_reset(32'h200, nopi(32'h200));
    step();
    pc = 32'h204; instr = EBRK; step();
    set_pc(32'h208); step();
    set_pc(32'h20C); step();
    set_pc(32'h210); step();
    set_pc(32'h214); step();
    pc = 32'h218; instr = WFI; step();
    set_pc(32'h21C); step();
    chk("mid.pre_valid", 32'(trace_valid), 32'd1);
    chk("mid.pre_ovf", 32'(overflow), 32'd1);
    chk("mid.pre_halted", 32'(halted), 32'd1);
    chk("mid.pre_err", 32'(error_count), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid.valid", 32'(trace_valid), 32'd0);
    chk("mid.ovf", 32'(overflow), 32'd0);
    chk("mid.halted", 32'(halted), 32'd0);
    chk("mid.err", 32'(error_count), 32'd0);
    chk("mid.pc", trace_pc, 32'd0);
    set_pc(32'h300);
    #2;
    rst_n = 1'b1;
    step();
    chk("mid.release_no_push", 32'(trace_valid), 32'd0);
    set_pc(32'h304); step();
    expect_rec("mid.rec", 32'h300, nopi(32'h300), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
